// File: rtl/fetch_line_buffer.sv
// -----------------------------------------------------------------------------
// fetch_line_buffer
//
// Frontend stage between the I-cache and decode. Holds one cache line with
// its fetch PC and streams it out as one instruction per cycle, each tagged
// with its PC. A fetch PC pointing into the middle of a line starts the
// stream at the addressed slot. A flush discards whatever is buffered.
//
// Build option:
//   FLB_BYPASS_EN - when defined, an empty buffer presents the addressed
//                   instruction of an incoming line in the same cycle
//                   (zero-cycle latency). When undefined, the first
//                   instruction appears one cycle after the line is taken
//                   and there is no combinational path line_i -> instr_o.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   flush_i        drop the buffered line (synchronous)
//   line_valid_i   cache line available
//   line_ready_o   buffer accepts a line this cycle
//   line_pc_i      fetch PC, may point anywhere inside the line
//   line_i         line data, slot k at bits [k*ILEN +: ILEN]
//   instr_valid_o  instruction available to decode
//   instr_ready_i  decode accepts the instruction
//   instr_o        instruction
//   instr_pc_o     PC of instr_o
// -----------------------------------------------------------------------------
module fetch_line_buffer #(
    parameter int XLEN       = 64,
    parameter int ILEN       = 32,
    parameter int LINE_INSTR = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       line_valid_i,
    output logic                       line_ready_o,
    input  logic [XLEN-1:0]            line_pc_i,
    input  logic [LINE_INSTR*ILEN-1:0] line_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [ILEN-1:0]            instr_o,
    output logic [XLEN-1:0]            instr_pc_o
);

    // Byte offset bits of one instruction and slot-index bits within a line.
    localparam int OFF    = $clog2(ILEN / 8);
    localparam int IDX    = $clog2(LINE_INSTR);
    localparam int BASE_W = XLEN - OFF - IDX;

    localparam logic [IDX-1:0] LAST_SLOT = IDX'(LINE_INSTR - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                            state_q;
    state_t                            state_d;
    logic [LINE_INSTR-1:0][ILEN-1:0]   line_q;
    logic [BASE_W-1:0]                 base_q;
    logic [IDX-1:0]                    idx_q;
    logic [IDX-1:0]                    idx_d;
    logic                              load_line;

    // Incoming line viewed as an array of slots, plus its PC split into
    // line base and starting slot.
    logic [LINE_INSTR-1:0][ILEN-1:0]   line_words;
    logic [BASE_W-1:0]                 line_base;
    logic [IDX-1:0]                    line_slot;
    logic                              last;
    logic                              line_hs;

    // The in-instruction byte offset of the fetch PC carries no information
    // for this stage (instructions are always slot aligned).
    logic                              unused_pc_offset;

    assign line_words       = line_i;
    assign line_base        = line_pc_i[XLEN-1:OFF+IDX];
    assign line_slot        = line_pc_i[OFF+IDX-1:OFF];
    assign last             = (idx_q == LAST_SLOT);
    assign unused_pc_offset = ^line_pc_i[OFF-1:0];

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        load_line     = 1'b0;
        line_hs       = 1'b0;
        line_ready_o  = 1'b0;
        instr_valid_o = 1'b0;
        instr_o       = line_q[idx_q];
        instr_pc_o    = {base_q, idx_q, {OFF{1'b0}}};

        unique case (state_q)
            EMPTY: begin
                line_ready_o = ~flush_i;
                line_hs      = line_valid_i & ~flush_i;
`ifdef FLB_BYPASS_EN
                // Present the addressed slot of the incoming line directly.
                if (line_valid_i && !flush_i) begin
                    instr_valid_o = 1'b1;
                    instr_o       = line_words[line_slot];
                    instr_pc_o    = {line_base, line_slot, {OFF{1'b0}}};
                end
`endif
                if (line_hs) begin
                    load_line = 1'b1;
                    idx_d     = line_slot;
                    state_d   = DRAIN;
`ifdef FLB_BYPASS_EN
                    // Decode already took the first slot; resume after it.
                    // If that was the last slot the line is fully consumed.
                    if (instr_ready_i) begin
                        idx_d = line_slot + IDX'(1);
                        if (line_slot == LAST_SLOT) begin
                            state_d = EMPTY;
                        end
                    end
`endif
                end
            end

            DRAIN: begin
                instr_valid_o = 1'b1;
                if (instr_ready_i) begin
                    if (!last) begin
                        idx_d = idx_q + IDX'(1);
                    end else begin
                        // The last slot leaves this cycle, so the next line
                        // can be taken on the same edge without a bubble.
                        line_ready_o = ~flush_i;
                        line_hs      = line_valid_i & ~flush_i;
                        if (line_hs) begin
                            load_line = 1'b1;
                            idx_d     = line_slot;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
            end

            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush overrides any progress made this cycle. line_ready_o is
        // already low, so no line can have been loaded.
        if (flush_i) begin
            state_d = EMPTY;
        end
    end

    // -------------------------------------------------------------------------
    // State and line storage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            base_q  <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (load_line) begin
                line_q <= line_words;
                base_q <= line_base;
            end
        end
    end

endmodule

// File: tb/tb_fetch_line_buffer.sv
module tb_fetch_line_buffer;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam int LI   = 16;
`ifdef FLB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              line_valid = 1'b0;
    logic              line_ready;
    logic [XLEN-1:0]   line_pc = '0;
    logic [LI*ILEN-1:0] line = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [ILEN-1:0]   instr;
    logic [XLEN-1:0]   instr_pc;

    fetch_line_buffer #(.XLEN(XLEN), .ILEN(ILEN), .LINE_INSTR(LI)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .line_valid_i  (line_valid),
        .line_ready_o  (line_ready),
        .line_pc_i     (line_pc),
        .line_i        (line),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Values seen just before the active edge.
    logic            obs_line_ready, obs_ivalid, obs_lhs, obs_ihs;
    logic [ILEN-1:0] obs_instr;
    logic [XLEN-1:0] obs_pc;

    // Instruction word encoding derived from its PC, so a wrong slot shows.
    function automatic logic [ILEN-1:0] instr_for(input logic [XLEN-1:0] pc);
        return {pc[15:0] ^ 16'hC3A5, ~pc[15:0]};
    endfunction

    task automatic set_line(input logic [XLEN-1:0] pc);
        logic [XLEN-1:0] wpc;
        line_pc = pc;
        for (int k = 0; k < LI; k++) begin
            wpc = {pc[XLEN-1:6], 4'(k), 2'b00};
            line[k*ILEN +: ILEN] = instr_for(wpc);
        end
    endtask

    // Sample on the falling edge, push expected stream on a line handshake,
    // then advance past the next rising edge.
    task automatic cycle();
        logic [XLEN-1:0] wpc;
        @(negedge clk);
        obs_line_ready = line_ready;
        obs_ivalid     = instr_valid;
        obs_instr      = instr;
        obs_pc         = instr_pc;
        obs_lhs        = line_valid & line_ready;
        obs_ihs        = instr_valid & instr_ready;
        if (obs_lhs) begin
            for (int k = int'(line_pc[5:2]); k < LI; k++) begin
                wpc = {line_pc[XLEN-1:6], 4'(k), 2'b00};
                exp_q.push_back('{pc: wpc, ins: instr_for(wpc)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; line_valid = 1'b0; instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
        tests++; if (instr !== '0) begin fails++; $display("FAIL reset_instr got=%h want=0", instr); end
        tests++; if (instr_pc !== '0) begin fails++; $display("FAIL reset_pc got=%h want=0", instr_pc); end
        tests++; if (line_ready !== 1'b1) begin fails++; $display("FAIL reset_line_ready got=%b want=1", line_ready); end
        flush = 1'b1;
        #1;
        tests++; if (line_ready !== 1'b0) begin fails++; $display("FAIL reset_flush_ready got=%b want=0", line_ready); end
        flush = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        tests++; if (obs_ivalid !== 1'b0) begin fails++; $display("FAIL idle_valid got=%b want=0", obs_ivalid); end
    endtask

    // Stream one line from pc with decode always ready; check latency,
    // throughput, stream content and line_ready on the last handshake.
    task automatic test_stream(input logic [XLEN-1:0] pc, input int n);
        exp_t e;
        int acc = -1, first = -1, lastc = -1, got = 0;
        set_line(pc); line_valid = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 60 && got < n; c++) begin
            cycle();
            if (obs_lhs) begin acc = c; line_valid = 1'b0; end
            if (obs_ihs) begin
                if (first < 0) first = c;
                lastc = c;
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL stream_extra got pc=%h want none", obs_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.ins) begin
                        fails++;
                        $display("FAIL stream_instr got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.ins);
                    end
                end
                if (got == n) begin
                    tests++;
                    if (obs_line_ready !== 1'b1) begin fails++; $display("FAIL stream_last_ready got=%b want=1", obs_line_ready); end
                end
            end
        end
        line_valid = 1'b0;
        tests++; if (got != n) begin fails++; $display("FAIL stream_count got=%0d want=%0d", got, n); end
        tests++; if (first - acc != LAT) begin fails++; $display("FAIL stream_latency got=%0d want=%0d", first - acc, LAT); end
        tests++; if (lastc - first != n - 1) begin fails++; $display("FAIL stream_span got=%0d want=%0d", lastc - first, n - 1); end
        cycle();
        tests++; if (obs_ivalid !== 1'b0) begin fails++; $display("FAIL stream_empty got=%b want=0", obs_ivalid); end
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL stream_left got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int nacc = 0, first = -1, lastc = -1, got = 0;
        set_line(64'h3000); line_valid = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 80 && got < 32; c++) begin
            cycle();
            if (obs_lhs) begin
                nacc++;
                if (nacc == 1) set_line(64'h3040);
                else line_valid = 1'b0;
            end
            if (obs_ihs) begin
                if (first < 0) first = c;
                lastc = c;
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL b2b_extra got pc=%h want none", obs_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.ins) begin
                        fails++;
                        $display("FAIL b2b_instr got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.ins);
                    end
                end
            end
        end
        line_valid = 1'b0;
        tests++; if (got != 32) begin fails++; $display("FAIL b2b_count got=%0d want=32", got); end
        tests++; if (lastc - first != 31) begin fails++; $display("FAIL b2b_bubble span got=%0d want=31", lastc - first); end
        cycle();
        exp_q.delete();
    endtask

    task automatic test_stall();
        exp_t e;
        int got = 0;
        set_line(64'h1000); line_valid = 1'b1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            instr_ready = !(c >= 2 + LAT && c < 7 + LAT);
            cycle();
            if (obs_lhs) line_valid = 1'b0;
            if (!instr_ready) begin
                tests++;
                if (exp_q.size() == 0 || obs_ivalid !== 1'b1 || obs_pc !== 64'h1008 ||
                    obs_instr !== exp_q[0].ins || obs_line_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_hold got v=%b pc=%h instr=%h lr=%b want v=1 pc=1008 instr=%h lr=0",
                             obs_ivalid, obs_pc, obs_instr, obs_line_ready, instr_for(64'h1008));
                end
            end
            if (obs_ihs) begin
                got++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL stall_extra got pc=%h want none", obs_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.ins) begin
                        fails++;
                        $display("FAIL stall_instr got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.ins);
                    end
                end
            end
        end
        instr_ready = 1'b1;
        tests++; if (got != 16) begin fails++; $display("FAIL stall_count got=%0d want=16", got); end
        cycle();
        exp_q.delete();
    endtask

    task automatic test_flush();
        exp_t e;
        int fc = 4 + LAT;
        set_line(64'h1000); line_valid = 1'b1; instr_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            flush = (c == fc);
            if (c == fc) begin set_line(64'h5000); line_valid = 1'b1; end
            cycle();
            if (obs_lhs) line_valid = 1'b0;
            if (c == fc) begin
                tests++; if (obs_line_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got=%b want=0", obs_line_ready); end
                tests++; if (obs_ihs !== 1'b1 || obs_pc !== 64'h1010) begin fails++; $display("FAIL flush_hs got hs=%b pc=%h want hs=1 pc=1010", obs_ihs, obs_pc); end
            end
            if (c == fc + 1) begin
                tests++; if (obs_ivalid !== (LAT == 0)) begin fails++; $display("FAIL flush_valid got=%b want=%b", obs_ivalid, LAT == 0); end
                tests++; if (obs_lhs !== 1'b1) begin fails++; $display("FAIL flush_reaccept got=%b want=1", obs_lhs); end
            end
            if (c == fc + 2) begin
                tests++;
                if (obs_ivalid !== 1'b1 || obs_pc !== 64'h5000 + 64'(4 * (1 - LAT))) begin
                    fails++; $display("FAIL flush_next got v=%b pc=%h want v=1 pc=%h", obs_ivalid, obs_pc, 64'h5000 + 64'(4 * (1 - LAT)));
                end
            end
            if (obs_ihs) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++; $display("FAIL flush_extra got pc=%h want none", obs_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (obs_pc !== e.pc || obs_instr !== e.ins) begin
                        fails++;
                        $display("FAIL flush_instr got pc=%h instr=%h want pc=%h instr=%h", obs_pc, obs_instr, e.pc, e.ins);
                    end
                end
            end
            if (c == fc) exp_q.delete();
        end
        flush = 1'b0;
        tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL flush_left got=%0d want=0", exp_q.size()); end
        exp_q.delete();
    endtask

`ifdef FLB_BYPASS_EN
    task automatic test_bypass();
        set_line(64'h4000); line_valid = 1'b1; instr_ready = 1'b1;
        cycle();
        line_valid = 1'b0;
        tests++; if (obs_ivalid !== 1'b1 || obs_pc !== 64'h4000 || obs_instr !== instr_for(64'h4000)) begin
            fails++; $display("FAIL bypass_first got v=%b pc=%h want v=1 pc=4000", obs_ivalid, obs_pc); end
        cycle();
        tests++; if (obs_ivalid !== 1'b1 || obs_pc !== 64'h4004) begin
            fails++; $display("FAIL bypass_second got v=%b pc=%h want v=1 pc=4004", obs_ivalid, obs_pc); end
        repeat (16) cycle();
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_mid_line();
        set_line(64'h6000); line_valid = 1'b1; instr_ready = 1'b1;
        cycle();
        line_valid = 1'b0;
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (instr_valid !== 1'b0 || instr_pc !== '0 || instr !== '0) begin
            fails++; $display("FAIL reset_mid got v=%b pc=%h instr=%h want v=0 pc=0 instr=0", instr_valid, instr_pc, instr); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_stream(64'h1000, 16);
        test_stream(64'h2038, 2);
        test_back_to_back();
        test_stall();
        test_flush();
`ifdef FLB_BYPASS_EN
        test_bypass();
`endif
        test_reset_mid_line();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
